la_acquire: RTL and testbench



---
 rtl/la_acquire.sv | 98 +++++++++
 tb/tb_la_acquire.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/la_acquire.sv
// la_acquire: pre/arm/post acquisition sequencer between the trigger stage and the capture stream.
module la_acquire #(
  parameter int DN = 2,
  parameter type DT = logic [7:0],
  parameter int CW = 32,
  parameter int DW = $bits(DT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctl_rst,
  input  logic               ctl_acq,
  input  logic               ctl_stp,
  input  logic               trg_in,
  input  logic [CW-1:0]      cfg_pre,
  input  logic [CW-1:0]      cfg_pst,
  output logic               sts_acq,
  output logic               sts_trg,
  output logic [CW-1:0]      sts_pre,
  output logic [CW-1:0]      sts_pst,
  input  logic [DN*DW-1:0]   sti_tdata,
  input  logic [DN-1:0]      sti_tkeep,
  input  logic               sti_tlast,
  input  logic               sti_tvalid,
  output logic               sti_tready,
  output logic [DN*DW-1:0]   sto_tdata,
  output logic [DN-1:0]      sto_tkeep,
  output logic               sto_tlast,
  output logic               sto_tvalid,
  input  logic               sto_tready
);
  typedef enum logic [1:0] {IDLE, PRE, ARM, POST} state_t;
  state_t state;
  logic beat, fwd, last, unused_tlast;
  logic [CW-1:0] pre_n, pst_n;
  assign unused_tlast = sti_tlast;
  assign sti_tready = ~sto_tvalid | sto_tready;
  assign beat = sti_tvalid & sti_tready;
  assign fwd = beat & (state != IDLE) & ~ctl_stp;
  assign pre_n = &sts_pre ? sts_pre : sts_pre + CW'(1);
  assign pst_n = sts_pst + CW'(1);
  assign last = (state == ARM && trg_in && cfg_pst == '0) || (state == POST && pst_n == cfg_pst);
  assign sts_acq = state != IDLE;
  assign sts_trg = state == POST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sts_pre <= '0;
      sts_pst <= '0;
      sto_tvalid <= 1'b0;
      sto_tlast <= 1'b0;
      sto_tdata <= '0;
      sto_tkeep <= '0;
    end else if (ctl_rst) begin
      state <= IDLE;
      sts_pre <= '0;
      sts_pst <= '0;
      sto_tvalid <= 1'b0;
      sto_tlast <= 1'b0;
      sto_tdata <= '0;
      sto_tkeep <= '0;
    end else begin
      if (fwd) begin
        sto_tvalid <= 1'b1;
        sto_tdata <= sti_tdata;
        sto_tkeep <= sti_tkeep;
        sto_tlast <= last;
      end else if (sto_tready) begin
        sto_tvalid <= 1'b0;
        sto_tlast <= 1'b0;
      end
      if (state == IDLE) begin
        if (ctl_acq && !ctl_stp) begin
          sts_pre <= '0;
          sts_pst <= '0;
          state <= cfg_pre == '0 ? ARM : PRE;
        end
      end else if (ctl_stp) begin
        state <= IDLE;
      end else if (beat) begin
        case (state)
          PRE: begin
            sts_pre <= pre_n;
            if (pre_n == cfg_pre) state <= ARM;
          end
          ARM: begin
            sts_pre <= pre_n;
            if (trg_in) state <= last ? IDLE : POST;
          end
          POST: begin
            sts_pst <= pst_n;
            if (last) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_la_acquire.sv
// tb_la_acquire: directed vectors and sequences checking the la_acquire sequencer.
module tb_la_acquire;
  logic clk = 0, rst = 1, ctl_rst = 0, ctl_acq = 0, ctl_stp = 0, trg_in = 0;
  logic [31:0] cfg_pre = 0, cfg_pst = 0;
  logic sts_acq, sts_trg;
  logic [31:0] sts_pre, sts_pst;
  logic [15:0] sti_tdata = 0, sto_tdata;
  logic [1:0] sti_tkeep = 2'b11, sto_tkeep;
  logic sti_tlast = 0, sti_tvalid = 0, sti_tready;
  logic sto_tlast, sto_tvalid, sto_tready = 1;
  int checks = 0, errors = 0, in_cnt = 0;
  bit rec = 0, last_seen = 0;
  logic [15:0] in_q[$];
  logic [16:0] out_q[$];

  la_acquire #(.DN(2), .DT(logic [7:0]), .CW(32)) dut (
    .clk(clk), .rst(rst), .ctl_rst(ctl_rst), .ctl_acq(ctl_acq), .ctl_stp(ctl_stp),
    .trg_in(trg_in), .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
    .sts_acq(sts_acq), .sts_trg(sts_trg), .sts_pre(sts_pre), .sts_pst(sts_pst),
    .sti_tdata(sti_tdata), .sti_tkeep(sti_tkeep), .sti_tlast(sti_tlast),
    .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
    .sto_tdata(sto_tdata), .sto_tkeep(sto_tkeep), .sto_tlast(sto_tlast),
    .sto_tvalid(sto_tvalid), .sto_tready(sto_tready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rec) begin
    if (sti_tvalid && sti_tready) begin
      in_q.push_back(sti_tdata);
      in_cnt++;
    end
    if (sto_tvalid && sto_tready) begin
      out_q.push_back({sto_tlast, sto_tdata});
      if (sto_tlast) last_seen = 1;
    end
  end

  typedef struct {
    logic cr, acq, stp, tv;
    logic [7:0] d;
    logic trg, rdy;
    logic [7:0] cpre, cpst;
    logic ov;
    logic [7:0] od;
    logic ol, sa, st;
    logic [7:0] sp, ss;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pk(input logic [7:0] b);
    return {~b, b};
  endfunction

  initial begin
    tbl[0]  = '{0,1,0,0,8'h00,0,1,0,0, 0,8'h00,0,1,0,0,0};
    tbl[1]  = '{0,0,0,1,8'h21,1,1,0,0, 1,8'h21,1,0,0,1,0};
    tbl[2]  = '{0,0,0,1,8'h22,0,1,0,0, 0,8'h00,0,0,0,1,0};
    tbl[3]  = '{0,0,0,0,8'h00,0,1,0,0, 0,8'h00,0,0,0,1,0};
    tbl[4]  = '{0,1,0,0,8'h00,0,1,0,5, 0,8'h00,0,1,0,0,0};
    tbl[5]  = '{0,0,0,1,8'h30,1,1,0,5, 1,8'h30,0,1,1,1,0};
    tbl[6]  = '{0,0,0,1,8'h31,0,0,0,5, 1,8'h30,0,1,1,1,0};
    tbl[7]  = '{0,0,0,1,8'h31,0,1,0,5, 1,8'h31,0,1,1,1,1};
    tbl[8]  = '{0,1,1,1,8'h32,0,0,0,5, 1,8'h31,0,0,0,1,1};
    tbl[9]  = '{0,0,0,1,8'h33,0,1,0,5, 0,8'h00,0,0,0,1,1};
    tbl[10] = '{0,1,0,0,8'h00,0,1,0,5, 0,8'h00,0,1,0,0,0};
    tbl[11] = '{0,0,1,1,8'h40,1,1,0,5, 0,8'h00,0,0,0,0,0};
    tbl[12] = '{0,1,0,0,8'h00,0,1,0,5, 0,8'h00,0,1,0,0,0};
    tbl[13] = '{0,0,0,1,8'h50,0,1,0,5, 1,8'h50,0,1,0,1,0};
    tbl[14] = '{1,1,0,1,8'h51,1,1,0,5, 0,8'h00,0,0,0,0,0};

    step(); step();
    rst = 0;
    step();
    chk("rst_tvalid", sto_tvalid, 0);
    chk("rst_acq", sts_acq, 0);
    chk("rst_cnt", {sts_pre, sts_pst}, 0);

    // ramp with trigger on data 10
    cfg_pre = 4; cfg_pst = 3;
    out_q.delete(); rec = 1;
    ctl_acq = 1; step(); ctl_acq = 0;
    chk("t1_acq", sts_acq, 1);
    for (int d = 0; d < 32; d++) begin
      sti_tvalid = 1; sti_tdata = pk(8'(d)); trg_in = (d == 10);
      step();
      if (d == 3) chk("t1_pre_trg", sts_trg, 0);
      if (d == 10) chk("t1_trg_acc", sts_trg, 1);
    end
    sti_tvalid = 0; trg_in = 0;
    step(); step();
    rec = 0;
    chk("t1_count", out_q.size(), 14);
    for (int i = 0; i < out_q.size() && i < 14; i++)
      chk($sformatf("t1_beat%0d", i), out_q[i], {(i == 13), pk(8'(i))});
    chk("t1_sts_pre", sts_pre, 11);
    chk("t1_sts_pst", sts_pst, 3);
    chk("t1_idle", {sts_acq, sts_trg}, 0);
    chk("t1_tkeep", sto_tkeep, 2'b11);

    // trigger only during PRE is ignored
    cfg_pre = 4; cfg_pst = 3;
    ctl_acq = 1; step(); ctl_acq = 0;
    for (int d = 0; d < 8; d++) begin
      sti_tvalid = 1; sti_tdata = pk(8'(d + 100)); trg_in = (d >= 1 && d <= 3);
      step();
      chk($sformatf("t2_notrg%0d", d), sts_trg, 0);
    end
    sti_tvalid = 0; trg_in = 0;
    chk("t2_armed", sts_acq, 1);
    chk("t2_sts_pre", sts_pre, 8);
    ctl_stp = 1; step(); ctl_stp = 0;
    chk("t2_stop", sts_acq, 0);
    step();

    // per-cycle vectors: zero-length capture, back-pressure, stop, soft reset
    foreach (tbl[i]) begin
      ctl_rst = tbl[i].cr; ctl_acq = tbl[i].acq; ctl_stp = tbl[i].stp;
      sti_tvalid = tbl[i].tv; sti_tdata = pk(tbl[i].d); trg_in = tbl[i].trg;
      sto_tready = tbl[i].rdy; cfg_pre = 32'(tbl[i].cpre); cfg_pst = 32'(tbl[i].cpst);
      step();
      chk($sformatf("v%0d_tvalid", i), sto_tvalid, tbl[i].ov);
      if (tbl[i].ov) begin
        chk($sformatf("v%0d_tdata", i), sto_tdata, pk(tbl[i].od));
        chk($sformatf("v%0d_tlast", i), sto_tlast, tbl[i].ol);
      end
      chk($sformatf("v%0d_sts", i), {sts_acq, sts_trg}, {tbl[i].sa, tbl[i].st});
      chk($sformatf("v%0d_cnt", i), {sts_pre, sts_pst}, {32'(tbl[i].sp), 32'(tbl[i].ss)});
    end
    ctl_rst = 0; ctl_acq = 0; ctl_stp = 0; sti_tvalid = 0; trg_in = 0; sto_tready = 1;
    step();

    // random valid/ready, trigger on input beat 6
    cfg_pre = 2; cfg_pst = 8;
    in_q.delete(); out_q.delete(); in_cnt = 0; last_seen = 0; rec = 1;
    ctl_acq = 1; step(); ctl_acq = 0;
    for (int c = 0; c < 400 && !last_seen; c++) begin
      sti_tvalid = 1'($urandom_range(0, 1));
      sto_tready = 1'($urandom_range(0, 1));
      sti_tdata = pk(8'(in_cnt * 7 + 3));
      trg_in = (in_cnt == 6);
      step();
    end
    sti_tvalid = 0; trg_in = 0; sto_tready = 1;
    step(); step(); step();
    rec = 0;
    chk("t4_last_seen", last_seen, 1);
    chk("t4_count", out_q.size(), 15);
    for (int i = 0; i < out_q.size() && i < in_q.size() && i < 15; i++)
      chk($sformatf("t4_beat%0d", i), out_q[i], {(i == 14), in_q[i]});
    chk("t4_sts_pst", sts_pst, 8);
    chk("t4_idle", sts_acq, 0);

    // asynchronous reset mid-POST with an output beat pending
    cfg_pre = 0; cfg_pst = 5;
    ctl_acq = 1; step(); ctl_acq = 0;
    sti_tvalid = 1; sti_tdata = pk(8'h77); trg_in = 1;
    step();
    sti_tvalid = 0; trg_in = 0; sto_tready = 0;
    step();
    chk("t6_pending", {sto_tvalid, sts_trg}, 2'b11);
    #2 rst = 1;
    #1;
    chk("t6_async_tvalid", sto_tvalid, 0);
    chk("t6_async_sts", {sts_acq, sts_trg}, 0);
    chk("t6_async_cnt", {sts_pre, sts_pst}, 0);
    step();
    rst = 0; sto_tready = 1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
